irq_pending_ctrl: RTL and testbench

- Downstream consumer of the interrupt edge-detection stage.
- Captures single-cycle rising-edge pulses from NUM_IRQ detectors into sticky pending bits and masks them with per-source enables.
- Selects the highest-priority pending source (lowest index wins) and presents it to the CPU-side interrupt interface with a req/ack handshake.
- Also reports lost events, meaning a pulse that arrives on an already-pending source.

---
 rtl/irq_pending_ctrl_pkg.sv | 34 +++
 rtl/irq_pending_ctrl_prio_enc.sv | 27 ++
 rtl/irq_pending_ctrl.sv | 124 ++++++++++++
 tb/tb_irq_pending_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared types and helpers for the interrupt pending controller.
package irq_pkg;

  localparam int unsigned NUM_IRQ_DEF = 8;
  localparam int unsigned MAX_IRQ     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic       found;
    logic [4:0] index;
  } prio_res_t;

  // Lowest set index wins; scanning downward lets the lowest hit overwrite the rest.
  function automatic prio_res_t prio_enc(input logic [MAX_IRQ-1:0] vec);
    prio_res_t res;
    res.found = 1'b0;
    res.index = 5'd0;
    for (int i = MAX_IRQ - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.index = 5'(i);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_pending_ctrl_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] vec,
  output logic               found,
  output logic [ID_W-1:0]    index
);

  logic [MAX_IRQ-1:0] vec_ext_s;
  prio_res_t          res_s;
  logic               unused_idx_s;

  // Widen to the helper's fixed width and narrow the result back to ID_W.
  always_comb begin
    vec_ext_s              = '0;
    vec_ext_s[NUM_IRQ-1:0] = vec;
    res_s                  = prio_enc(vec_ext_s);
    found                  = res_s.found;
    index                  = res_s.index[ID_W-1:0];
    unused_idx_s           = ^res_s.index;
  end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Sticky pending/overflow capture of interrupt edge pulses with a
// fixed-priority req/ack presentation to the CPU.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_pulse,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic [NUM_IRQ-1:0] sw_clr,
  input  logic               irq_ack,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] overflow
);

  irq_state_e         state_r;
  irq_state_e         state_n_s;
  logic               irq_req_r;
  logic               irq_req_n_s;
  logic [ID_W-1:0]    irq_id_r;
  logic [ID_W-1:0]    irq_id_n_s;
  logic [NUM_IRQ-1:0] pending_r;
  logic [NUM_IRQ-1:0] pending_n_s;
  logic [NUM_IRQ-1:0] overflow_r;
  logic [NUM_IRQ-1:0] overflow_n_s;
  logic [NUM_IRQ-1:0] masked_s;
  logic [NUM_IRQ-1:0] ack_clr_s;
  logic               ack_fire_s;
  logic               cand_found_s;
  logic [ID_W-1:0]    cand_id_s;

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .vec   (masked_s),
    .found (cand_found_s),
    .index (cand_id_s)
  );

  // Ack only counts while a request is actually presented; it clears the presented bit.
  always_comb begin
    masked_s   = pending_r & irq_en;
    ack_fire_s = (state_r == REQ) && irq_ack;
    ack_clr_s  = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (ack_fire_s && (irq_id_r == ID_W'(i))) begin
        ack_clr_s[i] = 1'b1;
      end else begin
        ack_clr_s[i] = 1'b0;
      end
    end
  end

  // A new pulse always beats a clear; a pulse on a pending bit is a lost event.
  always_comb begin
    pending_n_s  = irq_pulse | (pending_r & ~(sw_clr | ack_clr_s));
    overflow_n_s = (irq_pulse & pending_r) | (overflow_r & ~sw_clr);
  end

  // Request FSM: latch the winner in IDLE, hold it through REQ, one dead cycle in ACK.
  always_comb begin
    state_n_s   = state_r;
    irq_req_n_s = 1'b0;
    irq_id_n_s  = irq_id_r;
    case (state_r)
      IDLE: begin
        if (cand_found_s) begin
          state_n_s   = REQ;
          irq_req_n_s = 1'b1;
          irq_id_n_s  = cand_id_s;
        end else begin
          state_n_s   = IDLE;
          irq_req_n_s = 1'b0;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_n_s   = ACK;
          irq_req_n_s = 1'b0;
        end else begin
          state_n_s   = REQ;
          irq_req_n_s = 1'b1;
        end
      end
      ACK: begin
        state_n_s   = IDLE;
        irq_req_n_s = 1'b0;
      end
      default: begin
        state_n_s   = IDLE;
        irq_req_n_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      irq_req_r  <= 1'b0;
      irq_id_r   <= '0;
      pending_r  <= '0;
      overflow_r <= '0;
    end else begin
      state_r    <= state_n_s;
      irq_req_r  <= irq_req_n_s;
      irq_id_r   <= irq_id_n_s;
      pending_r  <= pending_n_s;
      overflow_r <= overflow_n_s;
    end
  end

  assign irq_req  = irq_req_r;
  assign irq_id   = irq_id_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed testbench for irq_pending_ctrl (NUM_IRQ=8).
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_pulse;
  logic [7:0] irq_en;
  logic [7:0] sw_clr;
  logic       irq_ack;
  logic       irq_req;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] overflow;

  int vectors;
  int miscompares;

  irq_pending_ctrl #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_pulse (irq_pulse),
    .irq_en    (irq_en),
    .sw_clr    (sw_clr),
    .irq_ack   (irq_ack),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; irq_pulse = 8'hFF; irq_en = 8'hFF; sw_clr = 8'h00; irq_ack = 1'b0;
    step(); step();
    rst = 1'b0; irq_pulse = 8'h00;
    vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL rst_pending got %h exp 00", pending); end
    vectors++; if (overflow !== 8'h00) begin miscompares++; $display("FAIL rst_overflow got %h exp 00", overflow); end
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", irq_req); end
    vectors++; if (irq_id !== 3'd0) begin miscompares++; $display("FAIL rst_id got %0d exp 0", irq_id); end
    step();
    vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL rst_no_capture got %h exp 00", pending); end
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL rst_no_req got %b exp 0", irq_req); end
  endtask

  task automatic test_basic();
    irq_en = 8'hFF;
    irq_pulse = 8'h20; step(); irq_pulse = 8'h00;
    vectors++; if (pending !== 8'h20) begin miscompares++; $display("FAIL basic_pending got %h exp 20", pending); end
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL basic_req_early got %b exp 0", irq_req); end
    step();
    vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL basic_req got %b exp 1", irq_req); end
    vectors++; if (irq_id !== 3'd5) begin miscompares++; $display("FAIL basic_id got %0d exp 5", irq_id); end
    step();
    vectors++; if (irq_req !== 1'b1) begin miscompares++; $display("FAIL basic_req_hold got %b exp 1", irq_req); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    vectors++; if (pending !== 8'h00) begin miscompares++; $display("FAIL basic_ack_pending got %h exp 00", pending); end
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL basic_ack_req got %b exp 0", irq_req); end
    step();
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL basic_idle_req got %b exp 0", irq_req); end
    vectors++; if (irq_id !== 3'd5) begin miscompares++; $display("FAIL basic_id_hold got %0d exp 5", irq_id); end
    step();
  endtask

  task automatic test_priority();
    irq_pulse = 8'h44; step(); irq_pulse = 8'h00;
    step();
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd2)) begin miscompares++; $display("FAIL prio_first got req=%b id=%0d exp req=1 id=2", irq_req, irq_id); end
    irq_pulse = 8'h01; step(); irq_pulse = 8'h00;
    vectors++; if (irq_id !== 3'd2) begin miscompares++; $display("FAIL prio_hold got %0d exp 2", irq_id); end
    vectors++; if (pending !== 8'h45) begin miscompares++; $display("FAIL prio_pending got %h exp 45", pending); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_ack_req got %b exp 0", irq_req); end
    step();
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL prio_gap_req got %b exp 0", irq_req); end
    step();
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd0)) begin miscompares++; $display("FAIL prio_second got req=%b id=%0d exp req=1 id=0", irq_req, irq_id); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step(); step();
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd6)) begin miscompares++; $display("FAIL prio_third got req=%b id=%0d exp req=1 id=6", irq_req, irq_id); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step(); step();
    vectors++; if ((irq_req !== 1'b0) || (pending !== 8'h00)) begin miscompares++; $display("FAIL prio_drained got req=%b pend=%h exp req=0 pend=00", irq_req, pending); end
    vectors++; if (overflow !== 8'h00) begin miscompares++; $display("FAIL prio_overflow got %h exp 00", overflow); end
  endtask

  task automatic test_enable();
    irq_en = 8'h00;
    irq_pulse = 8'h08; step(); irq_pulse = 8'h00;
    vectors++; if (pending !== 8'h08) begin miscompares++; $display("FAIL en_pending got %h exp 08", pending); end
    step(); step();
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL en_masked_req got %b exp 0", irq_req); end
    irq_en = 8'h08; step();
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd3)) begin miscompares++; $display("FAIL en_req got req=%b id=%0d exp req=1 id=3", irq_req, irq_id); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step(); step();
    vectors++; if ((pending !== 8'h00) || (irq_req !== 1'b0)) begin miscompares++; $display("FAIL en_drained got pend=%h req=%b exp pend=00 req=0", pending, irq_req); end
    irq_en = 8'hFF;
  endtask

  task automatic test_overflow();
    irq_pulse = 8'h10; step();
    vectors++; if ((pending !== 8'h10) || (overflow !== 8'h00)) begin miscompares++; $display("FAIL ovf_first got pend=%h ovf=%h exp pend=10 ovf=00", pending, overflow); end
    step(); irq_pulse = 8'h00;
    vectors++; if (overflow !== 8'h10) begin miscompares++; $display("FAIL ovf_set got %h exp 10", overflow); end
    irq_pulse = 8'h10; sw_clr = 8'h10; step(); irq_pulse = 8'h00; sw_clr = 8'h00;
    vectors++; if ((pending !== 8'h10) || (overflow !== 8'h10)) begin miscompares++; $display("FAIL ovf_set_wins got pend=%h ovf=%h exp pend=10 ovf=10", pending, overflow); end
    sw_clr = 8'h10; step(); sw_clr = 8'h00;
    vectors++; if ((pending !== 8'h00) || (overflow !== 8'h00)) begin miscompares++; $display("FAIL ovf_clr got pend=%h ovf=%h exp pend=00 ovf=00", pending, overflow); end
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd4)) begin miscompares++; $display("FAIL ovf_req_held got req=%b id=%0d exp req=1 id=4", irq_req, irq_id); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step(); step();
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL ovf_idle_req got %b exp 0", irq_req); end
  endtask

  task automatic test_back_to_back();
    irq_pulse = 8'h02; step(); irq_pulse = 8'h00;
    step();
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd1)) begin miscompares++; $display("FAIL b2b_req got req=%b id=%0d exp req=1 id=1", irq_req, irq_id); end
    irq_en = 8'hFD; irq_pulse = 8'h01; step(); irq_pulse = 8'h00;
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd1)) begin miscompares++; $display("FAIL b2b_hold got req=%b id=%0d exp req=1 id=1", irq_req, irq_id); end
    irq_ack = 1'b1; irq_pulse = 8'h02; step(); irq_ack = 1'b0; irq_pulse = 8'h00;
    vectors++; if (pending !== 8'h03) begin miscompares++; $display("FAIL b2b_pending got %h exp 03", pending); end
    vectors++; if (overflow !== 8'h02) begin miscompares++; $display("FAIL b2b_overflow got %h exp 02", overflow); end
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL b2b_ack_req got %b exp 0", irq_req); end
    step(); step();
    vectors++; if ((irq_req !== 1'b1) || (irq_id !== 3'd0)) begin miscompares++; $display("FAIL b2b_next got req=%b id=%0d exp req=1 id=0", irq_req, irq_id); end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if ((irq_req !== 1'b0) || (irq_id !== 3'd0)) begin miscompares++; $display("FAIL b2b_rst got req=%b id=%0d exp req=0 id=0", irq_req, irq_id); end
    vectors++; if ((pending !== 8'h00) || (overflow !== 8'h00)) begin miscompares++; $display("FAIL b2b_rst_regs got pend=%h ovf=%h exp 00 00", pending, overflow); end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step();
    vectors++; if (irq_req !== 1'b0) begin miscompares++; $display("FAIL b2b_stray_ack got %b exp 0", irq_req); end
    irq_en = 8'hFF;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_priority();
    test_enable();
    test_overflow();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
